shift_sequencer: RTL and testbench
==================================

Name: shift_sequencer

Overview:
Multi-cycle controller that turns the single-position shift/rotate datapath into a shift/rotate of 0..2^AMT_W-1 positions. It applies one single-position step per clock under a start/busy/done handshake. It uses the same 2-bit op encoding as the ALU shifter and sits between ALU control and the shifter result mux. The result is held stable until the next accepted start.

Parameters:
N, 8, data width in bits
AMT_W, $clog2(N)+1, width of the shift-amount input (4 when N=8; amounts 0..15)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE or DONE
op  input  2  00 ROR, 01 ROL, 10 SHR (logical, zero fill), 11 SHL (zero fill)
amount  input  AMT_W  number of single-position steps
din  input  N  operand, captured with start
busy  output  1  high while steps are in progress
done  output  1  one-cycle pulse when dout becomes valid
dout  output  N  result register, held until the next completion

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n. Asserting rst_n=0 forces state=IDLE, busy=0, done=0, dout=0, and clears the working register and the counter. This applies at any time, including mid-RUN; the partial result is discarded and no done pulse is produced.
- State machine:
  - IDLE: start=1 captures op, din into work_reg, and amount into cnt at that edge (E0). If amount=0, go to DONE with dout<=din. Otherwise go to RUN.
  - RUN: busy=1. Each edge sets work_reg<=step(work_reg,op) and cnt<=cnt-1. On the edge where cnt==1, dout<=step(work_reg,op) and the state goes to DONE. Exactly `amount` steps are applied, one per edge E1..Ea.
  - DONE: done=1 and busy=0 for exactly one cycle. start=1 in this cycle is accepted exactly as in IDLE (back-to-back operation). Otherwise the state returns to IDLE.
- Latency: done is high in the cycle following edge E_a (E0 when amount=0).
- start while in RUN is ignored. It is not queued and has no effect on op, din or cnt.
- op is latched at start; changing the op input during RUN has no effect.
- Width rules: the step is a pure N-bit operation with no carry or sign extension.
  - ROR: {w[0], w[N-1:1]}
  - ROL: {w[N-2:0], w[N-1]}
  - SHR: {1'b0, w[N-1:1]}
  - SHL: {w[N-2:0], 1'b0}
- Amounts of N or more are not reduced. A rotate by N yields the original operand; SHR or SHL by N or more yields 0. All such amounts still take the full `amount` cycles.
- Outputs are registered. busy is derived from state==RUN and done from state==DONE.
- dout changes only on the edge that raises done.

Decomposition:
- Package shift_pkg holds:
  - localparams OP_ROR=2'b00, OP_ROL=2'b01, OP_SHR=2'b10, OP_SHL=2'b11
  - state encoding ST_IDLE, ST_RUN, ST_DONE
- One combinational sub-module, shift_step #(N): inputs w[N-1:0] and op[1:0]; output w_next[N-1:0]. This is the single-position step.
- The FSM, counter, working register and output register live in shift_sequencer.

Test Plan:
- ROR, din=0x81, amount=1, start one cycle -> busy high 1 cycle, done pulse at E1, dout=0xC0.
- ROL, din=0x81, amount=3 -> busy for 3 cycles, done after E3, dout=0x0C. Re-assert start in the done cycle with SHR, din=0x80, amount=7 -> done after 7 more edges, dout=0x01.
- amount=0, din=0x5A, any op -> busy never asserts, done after E0, dout=0x5A.
- SHL, din=0xFF, amount=8 -> dout=0x00. ROR, din=0xA5, amount=8 -> dout=0xA5. SHR, din=0xFF, amount=15 -> dout=0x00 after 15 steps.
- During a ROL din=0x01 amount=5 run, pulse start with din=0xFF, op=SHL at cycle 2 -> ignored; dout=0x20 after E5.
- Drive rst_n low asynchronously mid-RUN (between clock edges) -> busy, done and dout go to 0 immediately. After release, there is no done pulse until a new start.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared op and state encodings for the multi-position shift/rotate sequencer.
// The op encoding matches the single-position ALU shifter.
package shift_pkg;

    localparam logic [1:0] OP_ROR = 2'b00;
    localparam logic [1:0] OP_ROL = 2'b01;
    localparam logic [1:0] OP_SHR = 2'b10;
    localparam logic [1:0] OP_SHL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_e;

endpackage

// File: rtl/shift_step.sv
// Single-position shift/rotate step: a pure N-bit operation with no carry
// out or sign extension.
module shift_step
    import shift_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0] w,
    input  logic [1:0]   op,
    output logic [N-1:0] w_next
);

    always_comb begin
        w_next = w;
        unique case (op)
            OP_ROR:  w_next = {w[0], w[N-1:1]};
            OP_ROL:  w_next = {w[N-2:0], w[N-1]};
            OP_SHR:  w_next = {1'b0, w[N-1:1]};
            OP_SHL:  w_next = {w[N-2:0], 1'b0};
            default: w_next = w;
        endcase
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift/rotate controller: applies `amount` single-position steps,
// one per clock, under a start/busy/done handshake; dout holds until the next completion.
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int N     = 8,
    parameter int AMT_W = $clog2(N) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [AMT_W-1:0] amount,
    input  logic [N-1:0]     din,
    output logic             busy,
    output logic             done,
    output logic [N-1:0]     dout
);

    state_e           state_q, state_d;
    logic [N-1:0]     work_q, work_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic [N-1:0]     dout_q, dout_d;
    logic [N-1:0]     step_w;

    shift_step #(.N(N)) u_step (
        .w      (work_q),
        .op     (op_q),
        .w_next (step_w)
    );

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        dout_d  = dout_q;
        unique case (state_q)
            // DONE accepts start exactly like IDLE so operations can run back-to-back.
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    op_d   = op;
                    work_d = din;
                    cnt_d  = amount;
                    if (amount == '0) begin
                        dout_d  = din;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                work_d = step_w;
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == AMT_W'(1)) begin
                    dout_d  = step_w;
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
            op_q    <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            dout_q  <= dout_d;
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);
    assign dout = dout_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed self-checking bench for shift_sequencer (N=8, AMT_W=4) with
// hand-computed expected results.
module tb_shift_sequencer;

    localparam int N     = 8;
    localparam int AMT_W = 4;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [1:0]       op;
    logic [AMT_W-1:0] amount;
    logic [N-1:0]     din;
    logic             busy;
    logic             done;
    logic [N-1:0]     dout;

    int n_checks = 0;
    int n_fails  = 0;

    shift_sequencer #(.N(N), .AMT_W(AMT_W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .amount (amount),
        .din    (din),
        .busy   (busy),
        .done   (done),
        .dout   (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Samples #1 after each edge until done; counts busy cycles seen before it.
    task automatic wait_done(output int busy_cycles, output logic ok);
        busy_cycles = 0;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                ok = 1'b1;
                return;
            end
            if (busy) busy_cycles++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input logic [1:0] o, input logic [N-1:0] d, input logic [AMT_W-1:0] a);
        op     = o;
        din    = d;
        amount = a;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [N-1:0] d,
                          input logic [AMT_W-1:0] a, input logic [N-1:0] exp);
        int   bc;
        logic ok;
        @(negedge clk);
        issue(o, d, a);
        wait_done(bc, ok);
        check_eq({tag, "_done_seen"}, 32'(ok), 32'd1);
        check_eq({tag, "_busy_cycles"}, 32'(bc), 32'(a));
        check_eq({tag, "_dout"}, 32'(dout), 32'(exp));
        @(posedge clk);
        #1;
        check_eq({tag, "_done_pulse_one_cycle"}, 32'(done), 32'd0);
        check_eq({tag, "_dout_held"}, 32'(dout), 32'(exp));
    endtask

    initial begin
        int   bc;
        logic ok;
        logic saw_done;

        rst_n  = 1'b0;
        start  = 1'b0;
        op     = 2'b00;
        amount = '0;
        din    = '0;
        #12;
        check_eq("reset_busy", 32'(busy), 32'd0);
        check_eq("reset_done", 32'(done), 32'd0);
        check_eq("reset_dout", 32'(dout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("ror1", 2'b00, 8'h81, 4'd1, 8'hC0);

        // Back-to-back: second start lands in the done cycle of the first.
        @(negedge clk);
        issue(2'b01, 8'h81, 4'd3);
        wait_done(bc, ok);
        check_eq("rol3_done_seen", 32'(ok), 32'd1);
        check_eq("rol3_busy_cycles", 32'(bc), 32'd3);
        check_eq("rol3_dout", 32'(dout), 32'h0C);
        issue(2'b10, 8'h80, 4'd7);
        check_eq("b2b_busy_after_restart", 32'(busy), 32'd1);
        check_eq("b2b_dout_held_during_run", 32'(dout), 32'h0C);
        wait_done(bc, ok);
        check_eq("shr7_done_seen", 32'(ok), 32'd1);
        check_eq("shr7_busy_cycles", 32'(bc), 32'd7);
        check_eq("shr7_dout", 32'(dout), 32'h01);

        run_op("amt0_shl", 2'b11, 8'h5A, 4'd0, 8'h5A);
        run_op("amt0_ror", 2'b00, 8'h5A, 4'd0, 8'h5A);
        run_op("shl8", 2'b11, 8'hFF, 4'd8, 8'h00);
        run_op("ror8", 2'b00, 8'hA5, 4'd8, 8'hA5);
        run_op("shr15", 2'b10, 8'hFF, 4'd15, 8'h00);
        run_op("rol8", 2'b01, 8'h3C, 4'd8, 8'h3C);
        run_op("shr2", 2'b10, 8'hB4, 4'd2, 8'h2D);

        // Start during RUN must be ignored, even with a different op/din.
        @(negedge clk);
        issue(2'b01, 8'h01, 4'd5);
        @(posedge clk);
        #1;
        issue(2'b11, 8'hFF, 4'd2);
        op  = 2'b10;
        din = 8'h00;
        wait_done(bc, ok);
        check_eq("ign_done_seen", 32'(ok), 32'd1);
        check_eq("ign_busy_remaining", 32'(bc), 32'd3);
        check_eq("ign_dout", 32'(dout), 32'h20);
        @(posedge clk);
        #1;
        check_eq("ign_no_second_done", 32'(done), 32'd0);

        // Asynchronous reset between edges in the middle of a run.
        @(negedge clk);
        issue(2'b11, 8'hFF, 4'd8);
        @(posedge clk);
        @(posedge clk);
        #3;
        check_eq("pre_rst_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_busy", 32'(busy), 32'd0);
        check_eq("async_rst_done", 32'(done), 32'd0);
        check_eq("async_rst_dout", 32'(dout), 32'd0);
        #3;
        rst_n = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) saw_done = 1'b1;
        end
        check_eq("post_rst_no_activity", 32'(saw_done), 32'd0);
        check_eq("post_rst_dout", 32'(dout), 32'd0);

        run_op("post_rst_rol2", 2'b01, 8'hC1, 4'd2, 8'h07);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #100000;
        n_fails++;
        $display("FAIL timeout: simulation exceeded time limit");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $fatal(1, "timeout");
    end

endmodule
